// File: rtl/uibi_pkg.sv
// uibi_pkg: shared UIBI constants, master indices, bus modes and interconnect FSM encoding
package uibi_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} uibi_state_e;
  localparam int UIBI_NM = 2;
  localparam int FETCH_NO = 0;
  localparam int LSU_NO = 1;
  localparam logic [2:0] BUS_FULL = 3'b111;
  localparam logic [2:0] BUS_HALF = 3'b011;
  localparam logic [2:0] BUS_QUARTER = 3'b001;
endpackage

// File: rtl/uibi_rr_picker.sv
// uibi_rr_picker: combinational round-robin pick of the first requester at or after ptr
module uibi_rr_picker
  import uibi_pkg::*;
#(
  parameter int NM = UIBI_NM,
  parameter int PW = 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);
  logic [PW-1:0] c;
  logic hit;
  assign valid_o = |req_i;
  always_comb begin
    idx_o = ptr_i;
    c = ptr_i;
    hit = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!hit && req_i[c]) begin
        idx_o = c;
        hit = 1'b1;
      end
      c = (c == PW'(NM - 1)) ? '0 : c + 1'b1;
    end
  end
endmodule

// File: rtl/uibi_interconnect.sv
// uibi_interconnect: round-robin shared-bus interconnect routing one master transaction at a time to a slave
module uibi_interconnect
  import uibi_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SLAVE_WIDTH = 2,
  parameter int NM = UIBI_NM,
  localparam int NS = 1 << SLAVE_WIDTH,
  localparam int AW = XLEN - SLAVE_WIDTH,
  localparam int PW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NM*XLEN-1:0]           master_dat_i,
  output logic [NM*XLEN-1:0]           master_dat_o,
  input  logic [NM*AW-1:0]             master_addr,
  input  logic [NM*SLAVE_WIDTH-1:0]    master_num,
  input  logic [NM-1:0]                master_req,
  input  logic [NM-1:0]                master_wen,
  input  logic [NM*3-1:0]              master_mode,
  output logic [NM-1:0]                master_ready,
  input  logic [NS*XLEN-1:0]           slave_dat_o,
  output logic [NS*XLEN-1:0]           slave_dat_i,
  output logic [NS*AW-1:0]             slave_addr,
  output logic [NS-1:0]                slave_req,
  output logic [NS-1:0]                slave_wen,
  output logic [NS*3-1:0]              slave_mode,
  input  logic [NS-1:0]                slave_ready
);
  uibi_state_e state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, g_q, g_d, win;
  logic [SLAVE_WIDTH-1:0] s_q, s_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic any_req;
  uibi_rr_picker #(.NM(NM), .PW(PW)) u_pick (
    .req_i(master_req),
    .ptr_i(rr_q),
    .valid_o(any_req),
    .idx_o(win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      g_q <= '0;
      s_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      g_q <= g_d;
      s_q <= s_d;
      rdata_q <= rdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    g_d = g_q;
    s_d = s_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = BUSY;
        g_d = win;
        s_d = master_num[win*SLAVE_WIDTH +: SLAVE_WIDTH];
      end
      BUSY: if (!master_req[g_q]) state_d = IDLE;
      else if (slave_ready[s_q]) begin
        state_d = DONE;
        rdata_d = master_wen[g_q] ? '0 : slave_dat_o[s_q*XLEN +: XLEN];
      end
      DONE: begin
        state_d = IDLE;
        rr_d = (g_q == PW'(NM - 1)) ? '0 : g_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    slave_req = '0;
    slave_dat_i = '0;
    slave_addr = '0;
    slave_wen = '0;
    slave_mode = '0;
    master_ready = '0;
    master_dat_o = '0;
    if (state_q == BUSY) begin
      slave_req[s_q] = 1'b1;
      slave_wen[s_q] = master_wen[g_q];
      slave_dat_i[s_q*XLEN +: XLEN] = master_dat_i[g_q*XLEN +: XLEN];
      slave_addr[s_q*AW +: AW] = master_addr[g_q*AW +: AW];
      slave_mode[s_q*3 +: 3] = master_mode[g_q*3 +: 3];
    end
    if (state_q == DONE) begin
      master_ready[g_q] = 1'b1;
      master_dat_o[g_q*XLEN +: XLEN] = rdata_q;
    end
  end
endmodule

// File: tb/tb_uibi_interconnect.sv
// tb_uibi_interconnect: randomized scoreboard bench with a transaction-level bus model
module tb_uibi_interconnect;
  localparam int XLEN = 32, SW = 2, NM = 2, NS = 4, AW = 30;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [XLEN-1:0] m_dat[NM];
  logic [AW-1:0] m_addr[NM];
  logic [SW-1:0] m_num[NM];
  logic m_req[NM];
  logic m_wen[NM];
  logic [2:0] m_mode[NM];
  logic [XLEN-1:0] s_rdat[NS];
  logic s_rdy[NS];
  logic [NM*XLEN-1:0] master_dat_i, master_dat_o;
  logic [NM*AW-1:0] master_addr;
  logic [NM*SW-1:0] master_num;
  logic [NM-1:0] master_req, master_wen, master_ready;
  logic [NM*3-1:0] master_mode;
  logic [NS*XLEN-1:0] slave_dat_o, slave_dat_i;
  logic [NS*AW-1:0] slave_addr;
  logic [NS-1:0] slave_req, slave_wen, slave_ready;
  logic [NS*3-1:0] slave_mode;
  always_comb begin
    master_dat_i = '0;
    master_addr = '0;
    master_num = '0;
    master_req = '0;
    master_wen = '0;
    master_mode = '0;
    slave_dat_o = '0;
    slave_ready = '0;
    for (int i = 0; i < NM; i++) begin
      master_dat_i[i*XLEN +: XLEN] = m_dat[i];
      master_addr[i*AW +: AW] = m_addr[i];
      master_num[i*SW +: SW] = m_num[i];
      master_req[i] = m_req[i];
      master_wen[i] = m_wen[i];
      master_mode[i*3 +: 3] = m_mode[i];
    end
    for (int i = 0; i < NS; i++) begin
      slave_dat_o[i*XLEN +: XLEN] = s_rdat[i];
      slave_ready[i] = s_rdy[i];
    end
  end
  uibi_interconnect #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .NM(NM)) dut (
    .clk(clk),
    .rst(rst),
    .master_dat_i(master_dat_i),
    .master_dat_o(master_dat_o),
    .master_addr(master_addr),
    .master_num(master_num),
    .master_req(master_req),
    .master_wen(master_wen),
    .master_mode(master_mode),
    .master_ready(master_ready),
    .slave_dat_o(slave_dat_o),
    .slave_dat_i(slave_dat_i),
    .slave_addr(slave_addr),
    .slave_req(slave_req),
    .slave_wen(slave_wen),
    .slave_mode(slave_mode),
    .slave_ready(slave_ready)
  );
  typedef struct {int g; logic [XLEN-1:0] d;} rsp_t;
  rsp_t rsp_q[$];
  int vecs = 0, errs = 0;
  bit own = 1'b0;
  int own_g = 0, own_s = 0, rr = 0;
  bit done = 1'b0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic fail(input string n);
    vecs++;
    errs++;
    $display("FAIL %s: got timeout expected completion", n);
  endtask
  always @(negedge clk) begin : mon
    logic [NS-1:0] e_sreq, e_swen;
    logic [NS*XLEN-1:0] e_sdat;
    logic [NS*AW-1:0] e_saddr;
    logic [NS*3-1:0] e_smode;
    logic [NM-1:0] e_mrdy;
    logic [NM*XLEN-1:0] e_mdat;
    rsp_t r;
    bit done_c;
    e_sreq = '0;
    e_swen = '0;
    e_sdat = '0;
    e_saddr = '0;
    e_smode = '0;
    e_mrdy = '0;
    e_mdat = '0;
    if (own) begin
      e_sreq[own_s] = 1'b1;
      e_swen[own_s] = m_wen[own_g];
      e_sdat[own_s*XLEN +: XLEN] = m_dat[own_g];
      e_saddr[own_s*AW +: AW] = m_addr[own_g];
      e_smode[own_s*3 +: 3] = m_mode[own_g];
    end
    done_c = rsp_q.size() != 0;
    if (done_c) begin
      r = rsp_q.pop_front();
      e_mrdy[r.g] = 1'b1;
      e_mdat[r.g*XLEN +: XLEN] = r.d;
      rr = (r.g + 1) % NM;
    end
    chk("slave_req", 128'(slave_req), 128'(e_sreq));
    chk("slave_wen", 128'(slave_wen), 128'(e_swen));
    chk("slave_dat", 128'(slave_dat_i), 128'(e_sdat));
    chk("slave_addr", 128'(slave_addr), 128'(e_saddr));
    chk("slave_mode", 128'(slave_mode), 128'(e_smode));
    chk("master_ready", 128'(master_ready), 128'(e_mrdy));
    chk("master_dat", 128'(master_dat_o), 128'(e_mdat));
    if (own) begin
      if (!m_req[own_g]) own = 1'b0;
      else if (s_rdy[own_s]) begin
        rsp_q.push_back('{own_g, m_wen[own_g] ? 32'h0 : s_rdat[own_s]});
        own = 1'b0;
      end
    end else if (!done_c) begin
      for (int k = 0; k < NM; k++) begin
        if (!own && m_req[(rr + k) % NM]) begin
          own = 1'b1;
          own_g = (rr + k) % NM;
          own_s = int'(m_num[own_g]);
        end
      end
    end
    if (rst) begin
      own = 1'b0;
      rr = 0;
      rsp_q.delete();
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue(input int m, input int num, input logic [AW-1:0] a, input logic w, input logic [2:0] md, input logic [XLEN-1:0] d);
    m_num[m] = SW'(num);
    m_addr[m] = a;
    m_wen[m] = w;
    m_mode[m] = md;
    m_dat[m] = d;
    m_req[m] = 1'b1;
  endtask
  task automatic pulse(input int s, input logic [XLEN-1:0] d);
    s_rdat[s] = d;
    s_rdy[s] = 1'b1;
    tick(1);
    for (int i = 0; i < NS; i++) s_rdy[i] = 1'b0;
  endtask
  task automatic wait_rdy(input int m);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!master_ready[m] && c < 100);
    if (!master_ready[m]) fail("ready_wait");
    tick(1);
    m_req[m] = 1'b0;
  endtask
  task automatic serve(input logic [XLEN-1:0] d);
    int c = 0;
    int s = 0;
    int m = 0;
    do begin
      @(negedge clk);
      c++;
    end while (slave_req == 0 && c < 100);
    if (slave_req == 0) fail("slave_req_wait");
    for (int i = 0; i < NS; i++) if (slave_req[i]) s = i;
    tick(1);
    pulse(s, d);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (master_ready == 0 && c < 100);
    if (master_ready == 0) fail("serve_ready_wait");
    for (int i = 0; i < NM; i++) if (master_ready[i]) m = i;
    tick(1);
    m_req[m] = 1'b0;
  endtask
  function automatic logic [2:0] rnd_mode();
    int k = $urandom_range(0, 2);
    return (k == 0) ? 3'b111 : (k == 1) ? 3'b011 : 3'b001;
  endfunction
  task automatic master_run(input int m, input int n);
    for (int t = 0; t < n; t++) begin
      tick($urandom_range(0, 3));
      issue(m, $urandom_range(0, NS - 1), AW'($urandom), 1'($urandom_range(0, 1)), rnd_mode(), $urandom);
      wait_rdy(m);
    end
  endtask
  task automatic responder();
    while (!done) begin
      @(negedge clk);
      if (slave_req != 0) begin
        int s = 0;
        for (int i = 0; i < NS; i++) if (slave_req[i]) s = i;
        tick($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) s_rdy[(s + 1) % NS] = 1'b1;
        pulse(s, $urandom);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < NM; i++) begin
      m_dat[i] = '0;
      m_addr[i] = '0;
      m_num[i] = '0;
      m_req[i] = 1'b0;
      m_wen[i] = 1'b0;
      m_mode[i] = '0;
    end
    for (int i = 0; i < NS; i++) begin
      s_rdat[i] = '0;
      s_rdy[i] = 1'b0;
    end
    tick(3);
    rst = 1'b0;
    tick(1);
    issue(0, 1, AW'('h10), 1'b0, 3'b111, $urandom);
    tick(3);
    pulse(1, 32'hDEADBEEF);
    wait_rdy(0);
    issue(1, 2, AW'($urandom), 1'b0, 3'b001, $urandom);
    tick(1);
    pulse(2, $urandom);
    wait_rdy(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      issue(0, $urandom_range(0, NS - 1), AW'($urandom), 1'b0, rnd_mode(), $urandom);
      issue(1, $urandom_range(0, NS - 1), AW'($urandom), 1'b0, rnd_mode(), $urandom);
      serve($urandom);
      serve($urandom);
    end
    issue(1, 3, AW'($urandom), 1'b1, 3'b011, 32'h1234);
    serve($urandom);
    issue(0, 0, AW'($urandom), 1'b0, 3'b111, $urandom);
    tick(1);
    pulse(2, $urandom);
    tick(1);
    pulse(0, $urandom);
    wait_rdy(0);
    issue(0, 1, AW'($urandom), 1'b0, 3'b111, $urandom);
    tick(1);
    rst = 1'b1;
    m_req[0] = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    issue(1, 2, AW'($urandom), 1'b0, 3'b111, $urandom);
    issue(0, 3, AW'($urandom), 1'b1, 3'b011, $urandom);
    serve($urandom);
    serve($urandom);
    issue(1, 2, AW'($urandom), 1'b0, 3'b111, $urandom);
    serve($urandom);
    issue(0, 1, AW'($urandom), 1'b0, 3'b111, $urandom);
    tick(1);
    m_req[0] = 1'b0;
    tick(1);
    pulse(1, $urandom);
    tick(2);
    fork
      begin
        fork
          master_run(0, 40);
          master_run(1, 40);
        join
        done = 1'b1;
      end
      responder();
    join
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog");
  end
endmodule
